// File: rtl/mem_arbiter.sv
// Byte-serial sequencer for the external memory bus, shared between instruction
// fetch (word reads) and the load/store buffer (1/2/4-byte reads and writes).
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10, DONE = 2'b11} state_t;

  state_t            state, state_nx;
  logic              last_ls, cur_ls, cur_we, cur_sgn;
  logic [1:0]        cur_size;
  logic [2:0]        n_bytes, idx, offset;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, data_buf, asm_data, if_data_hold, ls_rdata_hold;
  logic [7:0]        wr_byte;
  logic              grant, grant_ls, io_stall;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'b00:   extend = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign io_stall = (addr[17:16] == IO_HI) && io_buffer_full;

  // Arbitration and next-state selection.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_ls = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && (if_req || ls_req)) begin
          grant    = 1'b1;
          grant_ls = ls_req && (!if_req || !last_ls);
          state_nx = (grant_ls && ls_we) ? WR : RD;
        end else begin
          state_nx = IDLE;
        end
      end
      RD: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (idx == n_bytes) begin
          state_nx = DONE;
        end else begin
          state_nx = RD;
        end
      end
      WR: begin
        if (!io_stall && (idx == n_bytes - 3'd1)) begin
          state_nx = DONE;
        end else begin
          state_nx = WR;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // While rdy is low, keep the previous read address on the bus so the byte
  // returned after the freeze still belongs to the pending capture.
  always_comb begin
    if (state == RD && !rdy && idx != 3'd0) begin
      offset = idx - 3'd1;
    end else begin
      offset = idx;
    end
  end

  // Merge the incoming read byte into the assembly buffer.
  always_comb begin
    asm_data = data_buf;
    case (idx)
      3'd1:    asm_data[7:0]   = mem_din;
      3'd2:    asm_data[15:8]  = mem_din;
      3'd3:    asm_data[23:16] = mem_din;
      3'd4:    asm_data[31:24] = mem_din;
      default: asm_data        = data_buf;
    endcase
  end

  // Select the store byte for the current index.
  always_comb begin
    case (idx[1:0])
      2'd0:    wr_byte = wdata[7:0];
      2'd1:    wr_byte = wdata[15:8];
      2'd2:    wr_byte = wdata[23:16];
      default: wr_byte = wdata[31:24];
    endcase
  end

  assign mem_a    = (state == RD || state == WR) ? addr + ADDR_W'(offset) : {ADDR_W{1'b0}};
  assign mem_wr   = (state == WR) && rdy && !io_stall;
  assign mem_dout = (state == WR) ? wr_byte : 8'h00;

  // A flush suppresses fetch/load completion but never a committed store.
  assign if_done  = (state == DONE) && !cur_ls && rdy && !flush;
  assign ls_done  = (state == DONE) && cur_ls && rdy && (cur_we || !flush);
  assign if_data  = if_done ? data_buf : if_data_hold;
  assign ls_rdata = (ls_done && !cur_we) ? data_buf : ls_rdata_hold;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nx;
    end
  end

  // Request latching, byte indexing, read assembly and result holding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ls       <= 1'b1;
      cur_ls        <= 1'b0;
      cur_we        <= 1'b0;
      cur_sgn       <= 1'b0;
      cur_size      <= 2'b00;
      n_bytes       <= 3'd0;
      idx           <= 3'd0;
      addr          <= {ADDR_W{1'b0}};
      wdata         <= 32'h0;
      data_buf      <= 32'h0;
      if_data_hold  <= 32'h0;
      ls_rdata_hold <= 32'h0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (grant) begin
            last_ls <= grant_ls;
            cur_ls  <= grant_ls;
            idx     <= 3'd0;
            if (grant_ls) begin
              addr     <= ls_addr;
              cur_we   <= ls_we;
              cur_size <= ls_size;
              cur_sgn  <= ls_signed;
              wdata    <= ls_wdata;
              n_bytes  <= byte_count(ls_size);
            end else begin
              addr     <= if_addr;
              cur_we   <= 1'b0;
              cur_size <= 2'b10;
              cur_sgn  <= 1'b0;
              n_bytes  <= 3'd4;
            end
          end
        end
        RD: begin
          if (!flush) begin
            idx      <= idx + 3'd1;
            data_buf <= (idx == n_bytes) ? extend(asm_data, cur_size, cur_sgn) : asm_data;
          end
        end
        WR: begin
          if (!io_stall) begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (if_done) begin
            if_data_hold <= data_buf;
          end
          if (ls_done && !cur_we) begin
            ls_rdata_hold <= data_buf;
          end
        end
        default: idx <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-level bench for mem_arbiter with a one-cycle-latency ROM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, if_req, ls_req, ls_we, ls_signed, io_buffer_full;
  logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata;
  logic [1:0]  ls_size;
  logic        if_done, ls_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;

  int checks = 0;
  int errors = 0;
  int cyc, n;
  logic [7:0] sw_bytes [4];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: rom = 8'h13;
      32'h101: rom = 8'h05;
      32'h200: rom = 8'h80;
      32'h201: rom = 8'h11;
      32'h202: rom = 8'h22;
      32'h203: rom = 8'h33;
      32'h210: rom = 8'h01;
      32'h211: rom = 8'h80;
      default: rom = 8'h00;
    endcase
  endfunction

  always @(posedge clk) mem_din <= rom(mem_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ls(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (ls_done !== 1'b1 && c < 40);
  endtask

  task automatic wait_if(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (if_done !== 1'b1 && c < 40);
  endtask

  task automatic load(input logic [1:0] size, input logic sgn, input logic [31:0] a,
                      input int exp_lat, input logic [31:0] exp_data, input string tag);
    int c;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = size; ls_signed = sgn; ls_addr = a;
    wait_ls(c);
    chk({tag, "_lat"}, c, exp_lat);
    chk({tag, "_data"}, ls_rdata, exp_data);
    ls_req = 1'b0;
    tick();
    chk({tag, "_hold"}, ls_rdata, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0; io_buffer_full = 1'b0;
    #3;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", mem_wr, 32'h0);
    chk("rst_mem_dout", mem_dout, 32'h0);
    chk("rst_if_done", if_done, 32'h0);
    chk("rst_ls_done", ls_done, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // fetch of 0x100: bus walks 0x100..0x103, done six cycles after grant
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("f_a0", mem_a, 32'h100);
    chk("f_wr0", mem_wr, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("f_a", mem_a, 32'h100 + 32'(i));
    end
    tick();
    chk("f_early_done", if_done, 32'h0);
    tick();
    if_req = 1'b0; #1;
    chk("f_done", if_done, 32'h1);
    chk("f_data", if_data, 32'h00000513);
    chk("f_ls_quiet", ls_done, 32'h0);
    tick();
    chk("f_done_pulse", if_done, 32'h0);
    chk("f_data_hold", if_data, 32'h00000513);

    load(2'b00, 1'b1, 32'h200, 3, 32'hFFFFFF80, "lb_s");
    load(2'b00, 1'b0, 32'h200, 3, 32'h00000080, "lb_u");
    load(2'b01, 1'b1, 32'h210, 4, 32'hFFFF8001, "lh_s");
    load(2'b11, 1'b0, 32'h200, 6, 32'h33221180, "lw_sz3");

    // word store
    sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sw_wr", mem_wr, 32'h1);
      chk("sw_a", mem_a, 32'h300 + 32'(i));
      chk("sw_dout", mem_dout, 32'(sw_bytes[i]));
    end
    tick();
    chk("sw_done", ls_done, 32'h1);
    chk("sw_wr_end", mem_wr, 32'h0);
    ls_req = 1'b0;
    tick();

    // half store across the address wrap
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'hFFFFFFFF; ls_wdata = 32'h0000A55A;
    tick();
    chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    chk("wrap_d0", mem_dout, 32'h5A);
    tick();
    chk("wrap_a1", mem_a, 32'h0);
    chk("wrap_d1", mem_dout, 32'hA5);
    chk("wrap_wr1", mem_wr, 32'h1);
    tick();
    chk("wrap_done", ls_done, 32'h1);
    ls_req = 1'b0;
    tick();

    // contention: fetch, then load, then fetch again
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h200;
    tick();
    chk("arb_first_if", mem_a, 32'h100);
    wait_if(cyc);
    chk("arb_if_lat", cyc, 32'd5);
    chk("arb_if_data", if_data, 32'h00000513);
    tick();
    tick();
    chk("arb_ls_next", mem_a, 32'h200);
    wait_ls(cyc);
    chk("arb_ls_lat", cyc, 32'd5);
    chk("arb_ls_data", ls_rdata, 32'h33221180);
    tick();
    tick();
    chk("arb_back_if", mem_a, 32'h100);
    ls_req = 1'b0;
    wait_if(cyc);
    chk("arb_if2_lat", cyc, 32'd5);
    if_req = 1'b0;
    tick();

    // UART store stalled by a full TX buffer
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_stall_wr", mem_wr, 32'h0);
    end
    tick();
    io_buffer_full = 1'b0; #1;
    chk("io_wr", mem_wr, 32'h1);
    chk("io_dout", mem_dout, 32'h41);
    chk("io_a", mem_a, 32'h30000);
    tick();
    chk("io_done", ls_done, 32'h1);
    ls_req = 1'b0;
    tick();

    // rdy low for two cycles in the middle of a word load
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h200;
    tick(); tick(); tick();
    rdy = 1'b0; #1;
    chk("rdy_no_done", ls_done, 32'h0);
    tick(); tick();
    rdy = 1'b1;
    wait_ls(cyc);
    chk("rdy_lat", cyc, 32'd3);
    chk("rdy_data", ls_rdata, 32'h33221180);
    ls_req = 1'b0;
    tick();

    // flush during the second byte of a fetch
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    flush = 1'b1; if_req = 1'b0; #1;
    chk("flf_no_done", if_done, 32'h0);
    tick();
    flush = 1'b0; #1;
    chk("flf_idle", mem_a, 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_done === 1'b1) n++;
    end
    chk("flf_done_count", n, 32'd0);

    // flush during the second byte of a word store
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'h12345678;
    tick();
    chk("fls_d0", mem_dout, 32'h78);
    tick();
    flush = 1'b1; #1;
    chk("fls_a1", mem_a, 32'h301);
    chk("fls_d1", mem_dout, 32'h56);
    chk("fls_wr1", mem_wr, 32'h1);
    tick();
    flush = 1'b0; #1;
    chk("fls_a2", mem_a, 32'h302);
    chk("fls_d2", mem_dout, 32'h34);
    tick();
    chk("fls_d3", mem_dout, 32'h12);
    tick();
    flush = 1'b1; #1;
    chk("fls_done", ls_done, 32'h1);
    flush = 1'b0; ls_req = 1'b0;
    tick();
    chk("fls_done_pulse", ls_done, 32'h0);

    // reset in the middle of a fetch aborts it
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    rst = 1'b0; if_req = 1'b0; #1;
    chk("rmid_a", mem_a, 32'h0);
    chk("rmid_if_data", if_data, 32'h0);
    tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_done === 1'b1) n++;
    end
    chk("rmid_done_count", n, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
